// File: rtl/demorgan_selftest.sv
// Self-test sequencer for the De Morgan gate block: walks A/B through all four
// vectors, checks the eight gate outputs and reports errors.
// Optional macro DEMORGAN_SELFTEST_FAILMASK_EN adds the sticky fail_mask output.
module demorgan_selftest #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  input  logic [7:0]       obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       first_fail_vec
`ifdef DEMORGAN_SELFTEST_FAILMASK_EN
  ,
  output logic [7:0]       fail_mask
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned POP_W = 4;
  localparam int unsigned SUM_W = ERR_W + POP_W;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  // SETTLE lasts SETTLE_CYCLES cycles; with zero settle time it is skipped.
  localparam state_t ENTRY_STATE = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       vec;
  logic [1:0]       vec_next;
  logic [CNT_W-1:0] settle_cnt;
  logic [7:0]       expected;
  logic [7:0]       mismatch;
  logic [POP_W-1:0] bit_errs;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_next;

  // Reference gate outputs for the current vector, a = vec[1], b = vec[0].
  always_comb begin
    expected = {~vec[1], ~vec[0], vec[1] & vec[0], vec[1] | vec[0],
                ~(vec[1] | vec[0]), ~(vec[1] & vec[0]),
                ~(vec[1] | vec[0]), ~(vec[1] & vec[0])};
    mismatch = obs ^ expected;
    vec_next = vec + 2'd1;
  end

  // Saturating accumulation of the per-vector bit-error popcount.
  always_comb begin
    bit_errs = '0;
    for (int i = 0; i < 8; i++) begin
      bit_errs = bit_errs + POP_W'(mismatch[i]);
    end
    err_sum  = SUM_W'(err_count) + SUM_W'(bit_errs);
    err_next = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : ERR_W'(err_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      vec            <= '0;
      settle_cnt     <= '0;
      drv_a          <= 1'b0;
      drv_b          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
`ifdef DEMORGAN_SELFTEST_FAILMASK_EN
      fail_mask      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= ENTRY_STATE;
            vec            <= '0;
            drv_a          <= 1'b0;
            drv_b          <= 1'b0;
            settle_cnt     <= SETTLE_LOAD;
            busy           <= 1'b1;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
`ifdef DEMORGAN_SELFTEST_FAILMASK_EN
            fail_mask      <= '0;
`endif
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        CHECK: begin
          err_count <= err_next;
          if ((mismatch != '0) && !fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_vec <= vec;
          end
`ifdef DEMORGAN_SELFTEST_FAILMASK_EN
          fail_mask <= fail_mask | mismatch;
`endif
          if (vec != 2'd3) begin
            vec        <= vec_next;
            drv_a      <= vec_next[1];
            drv_b      <= vec_next[0];
            settle_cnt <= SETTLE_LOAD;
            state      <= ENTRY_STATE;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_selftest.sv
// Directed bench for demorgan_selftest: one instance with SETTLE_CYCLES=2 and
// one with SETTLE_CYCLES=0, each fed by a behavioural gate model with faults.
module tb_demorgan_selftest;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   mode0  = 0;
  int   mode1  = 0;
  int   sel    = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       drv_a0, drv_b0, busy0, done0, pass0, fv0;
  logic       drv_a1, drv_b1, busy1, done1, pass1, fv1;
  logic [3:0] err0, err1;
  logic [1:0] ff0, ff1;
  logic [7:0] obs0, obs1;
`ifdef DEMORGAN_SELFTEST_FAILMASK_EN
  logic [7:0] mask0, mask1;
`endif

  always #5 clk = ~clk;

  // Gate model; mode 1: AandB stuck at 1, 2: all zero, 3: bit 0 flipped at {A,B}=10.
  function automatic logic [7:0] gate(input logic a, input logic b, input int mode);
    logic [7:0] g;
    g = {~a, ~b, a & b, a | b, ~(a | b), ~(a & b), ~(a | b), ~(a & b)};
    case (mode)
      1: g[5] = 1'b1;
      2: g = 8'h00;
      3: if (a && !b) g[0] = ~g[0];
      default: ;
    endcase
    return g;
  endfunction

  assign obs0 = gate(drv_a0, drv_b0, mode0);
  assign obs1 = gate(drv_a1, drv_b1, mode1);

  demorgan_selftest #(.SETTLE_CYCLES(2), .ERR_W(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .drv_a(drv_a0), .drv_b(drv_b0),
    .obs(obs0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail_vec(ff0)
`ifdef DEMORGAN_SELFTEST_FAILMASK_EN
    , .fail_mask(mask0)
`endif
  );

  demorgan_selftest #(.SETTLE_CYCLES(0), .ERR_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .drv_a(drv_a1), .drv_b(drv_b1),
    .obs(obs1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_vec(ff1)
`ifdef DEMORGAN_SELFTEST_FAILMASK_EN
    , .fail_mask(mask1)
`endif
  );

  logic       s_a, s_b, s_busy, s_done, s_pass, s_fv;
  logic [3:0] s_err;
  logic [1:0] s_ff;
  assign s_a    = (sel == 0) ? drv_a0 : drv_a1;
  assign s_b    = (sel == 0) ? drv_b0 : drv_b1;
  assign s_busy = (sel == 0) ? busy0  : busy1;
  assign s_done = (sel == 0) ? done0  : done1;
  assign s_pass = (sel == 0) ? pass0  : pass1;
  assign s_fv   = (sel == 0) ? fv0    : fv1;
  assign s_err  = (sel == 0) ? err0   : err1;
  assign s_ff   = (sel == 0) ? ff0    : ff1;
`ifdef DEMORGAN_SELFTEST_FAILMASK_EN
  logic [7:0] s_mask;
  assign s_mask = (sel == 0) ? mask0 : mask1;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v;
    else start1 = v;
  endtask

  // Called at a falling edge; start is raised for the following rising edge.
  task automatic run(input int settle, input logic [3:0] e_err, input logic e_valid,
                     input logic [1:0] e_first, input logic [7:0] e_mask,
                     input logic e_pass, input logic prev_pass, input bit hold);
    int total;
    total = 4 * (settle + 1);
    set_start(1'b1);
    @(negedge clk);
    for (int i = 1; i <= total; i++) begin
      if (!hold) set_start(1'b0);
      check("busy_run", 32'(s_busy), 32'(1));
      check("done_early", 32'(s_done), 32'(0));
      check("drv_vec", 32'({s_a, s_b}), 32'((i - 1) / (settle + 1)));
      if (i == 1) begin
        check("pass_hold", 32'(s_pass), 32'(prev_pass));
        check("err_clear", 32'(s_err), 32'(0));
        check("fv_clear", 32'(s_fv), 32'(0));
      end
      @(negedge clk);
    end
    check("done_pulse", 32'(s_done), 32'(1));
    check("busy_done", 32'(s_busy), 32'(0));
    check("pass", 32'(s_pass), 32'(e_pass));
    check("err_count", 32'(s_err), 32'(e_err));
    check("fail_valid", 32'(s_fv), 32'(e_valid));
    if (e_valid) check("first_fail_vec", 32'(s_ff), 32'(e_first));
`ifdef DEMORGAN_SELFTEST_FAILMASK_EN
    check("fail_mask", 32'(s_mask), 32'(e_mask));
`else
    if (e_mask == 8'hxx) $display("[TB] unexpected mask argument");
`endif
    @(negedge clk);
    set_start(1'b0);
    check("done_low", 32'(s_done), 32'(0));
    check("busy_idle", 32'(s_busy), 32'(0));
    check("drv_hold", 32'({s_a, s_b}), 32'(3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'(0));
    check("rst_done", 32'(done0), 32'(0));
    check("rst_pass", 32'(pass0), 32'(0));
    check("rst_err", 32'(err0), 32'(0));
    check("rst_drv", 32'({drv_a0, drv_b0}), 32'(0));
    check("rst_fv", 32'(fv0), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    sel = 0;
    mode0 = 0; run(2, 4'd0,  1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    mode0 = 1; run(2, 4'd3,  1'b1, 2'd0, 8'h20, 1'b0, 1'b1, 1'b0);
    mode0 = 2; run(2, 4'd15, 1'b1, 2'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
    mode0 = 3; run(2, 4'd1,  1'b1, 2'd2, 8'h01, 1'b0, 1'b0, 1'b0);
    mode0 = 0; run(2, 4'd0,  1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
    run(2, 4'd0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Abort a faulty run at busy cycle 6 with reset.
    mode0 = 1;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (5) @(negedge clk);
    check("abort_busy", 32'(busy0), 32'(1));
    check("abort_err", 32'(err0), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy0", 32'(busy0), 32'(0));
    check("abort_done0", 32'(done0), 32'(0));
    check("abort_pass0", 32'(pass0), 32'(0));
    check("abort_err0", 32'(err0), 32'(0));
    check("abort_fv0", 32'(fv0), 32'(0));
    check("abort_drv0", 32'({drv_a0, drv_b0}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done0), 32'(0));
    end
    mode0 = 0; run(2, 4'd0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);

    sel = 1;
    mode1 = 0; run(0, 4'd0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    mode1 = 1; run(0, 4'd3, 1'b1, 2'd0, 8'h20, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
